// File: rtl/channel_impair.sv
`default_nettype none
// ============================================================================
//  Module   : channel_impair
//  Brief    : Fixed-latency link channel model with LFSR-driven error injection
//             (bit flips, inverted bursts, erasures) and a corrupted-word count.
//  Revision : 1.0 - initial release
// ============================================================================
module channel_impair #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DELAY     = 4,
    parameter int unsigned BURST_LEN = 4,
    parameter logic [31:0] LFSR_SEED = 32'hACE12468,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [7:0]        err_thresh,
    input  logic              force_err,
    input  logic              clr_cnt,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              err_flag_o,
    output logic [CNT_W-1:0]  err_cnt_o
);

    localparam int unsigned     c_bc_w       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [c_bc_w-1:0] c_burst_load = c_bc_w'(BURST_LEN - 1);
    localparam logic [31:0]     c_poly       = 32'h8020_0003;
    localparam logic [1:0]      c_mode_clean = 2'd0;
    localparam logic [1:0]      c_mode_flip  = 2'd1;
    localparam logic [1:0]      c_mode_burst = 2'd2;
    localparam logic [1:0]      c_mode_erase = 2'd3;

    logic [31:0]       r_lfsr;
    logic [c_bc_w-1:0] r_burst;
    logic              r_valid [DELAY];
    logic [DATA_W-1:0] r_data  [DELAY];
    logic              r_flag  [DELAY];
    logic [CNT_W-1:0]  r_err_cnt;

    logic              w_event;
    logic [31:0]       w_bit_idx;
    logic [DATA_W-1:0] w_flip_mask;
    logic [DATA_W-1:0] w_data;
    logic              w_flag;
    logic [c_bc_w-1:0] w_burst_nxt;
    logic [31:0]       w_lfsr_nxt;

    assign w_event     = valid_i & en & (force_err | (r_lfsr[7:0] < err_thresh));
    assign w_bit_idx   = {24'd0, r_lfsr[15:8]} % DATA_W;
    assign w_flip_mask = DATA_W'(1) << w_bit_idx;
    // Right-shifting Galois form of x^32+x^22+x^2+x+1
    assign w_lfsr_nxt  = (r_lfsr >> 1) ^ (r_lfsr[0] ? c_poly : 32'h0);

    always_comb begin
        w_data      = data_i;
        w_flag      = 1'b0;
        w_burst_nxt = '0;
        case (mode)
            c_mode_clean: begin
                w_data = data_i;
            end
            c_mode_flip: begin
                if (w_event) begin
                    w_data = data_i ^ w_flip_mask;
                    w_flag = 1'b1;
                end
            end
            c_mode_burst: begin
                w_burst_nxt = r_burst;
                // An active burst owns the word; new events are ignored until it drains
                if (valid_i && (r_burst != '0)) begin
                    w_data      = ~data_i;
                    w_flag      = 1'b1;
                    w_burst_nxt = r_burst - c_bc_w'(1);
                end else if (w_event) begin
                    w_data      = ~data_i;
                    w_flag      = 1'b1;
                    w_burst_nxt = c_burst_load;
                end
            end
            c_mode_erase: begin
                if (w_event) begin
                    w_data = '0;
                    w_flag = 1'b1;
                end
            end
            default: begin
                w_data = data_i;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr     <= LFSR_SEED;
            r_burst    <= '0;
            r_valid[0] <= 1'b0;
            r_data[0]  <= '0;
            r_flag[0]  <= 1'b0;
        end else if (en) begin
            r_lfsr     <= w_lfsr_nxt;
            r_burst    <= w_burst_nxt;
            r_valid[0] <= valid_i;
            r_data[0]  <= w_data;
            r_flag[0]  <= w_flag;
        end
    end

    for (genvar i = 1; i < DELAY; i++) begin : g_stage
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid[i] <= 1'b0;
                r_data[i]  <= '0;
                r_flag[i]  <= 1'b0;
            end else if (en) begin
                r_valid[i] <= r_valid[i-1];
                r_data[i]  <= r_data[i-1];
                r_flag[i]  <= r_flag[i-1];
            end
        end
    end

    assign valid_o    = r_valid[DELAY-1] & en;
    assign data_o     = r_data[DELAY-1];
    assign err_flag_o = r_flag[DELAY-1];
    assign err_cnt_o  = r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (clr_cnt) begin
            r_err_cnt <= '0;
        end else if (valid_o && err_flag_o && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire
